// File: rtl/dmem_pkg.sv
// Shared size encodings, FSM states and lane helpers for data_mem_ctrl.
// Defining DMEM_SPLIT_EN adds the ST_BEAT2 state for word-crossing accesses.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

`ifdef DMEM_SPLIT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RESP = 2'd1, ST_BEAT2 = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RESP = 2'd1} state_t;
`endif

  function automatic logic size_legal(input logic [2:0] sz);
    return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W) || (sz == SZ_BU) || (sz == SZ_HU);
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz_lo);
    logic [2:0] n;
    case (sz_lo)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      2'b10:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Bits [3:0] are lanes of the addressed word, bits [7:4] lanes of the next word.
  function automatic logic [7:0] lane_mask(input logic [2:0] n, input logic [1:0] off);
    logic [7:0] m;
    case (n)
      3'd1:    m = 8'h01;
      3'd2:    m = 8'h03;
      3'd4:    m = 8'h0F;
      default: m = 8'h00;
    endcase
    return m << off;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] sz, input logic [31:0] v);
    logic [31:0] ext;
    case (sz)
      SZ_B:    ext = {{24{v[7]}}, v[7:0]};
      SZ_H:    ext = {{16{v[15]}}, v[15:0]};
      SZ_BU:   ext = {24'h0, v[7:0]};
      SZ_HU:   ext = {16'h0, v[15:0]};
      default: ext = v;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Four byte-wide synchronous RAM lanes with per-lane write enable.
// Read data is registered (1 cycle) and holds while i_en is low; contents are not reset.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_mem [DEPTH_WORDS];
    logic [7:0] r_rd;

    always_ff @(posedge clk) begin
      if (i_en) begin
        if (i_we[g]) r_mem[i_addr] <= i_wdata[8*g +: 8];
        r_rd <= r_mem[i_addr];
      end
    end

    assign o_rdata[8*g +: 8] = r_rd;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked RV32 data memory: response 1 cycle after accept (2 when split via DMEM_SPLIT_EN).
// req_ready only in IDLE; the response is held until rsp_ready.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      r_state;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic        r_err;
  logic        r_we;
  logic [2:0]  r_size;
  logic [1:0]  r_off;

  logic [1:0]  w_off;
  logic [AW-1:0] w_word;
  logic [2:0]  w_n;
  logic [7:0]  w_mask8;
  logic        w_cross;
  logic        w_oob;
  logic        w_err;
  logic        w_accept;
  logic [31:0] w_wdata_lo;

  logic        w_bank_en;
  logic [3:0]  w_bank_we;
  logic [AW-1:0] w_bank_addr;
  logic [31:0] w_bank_wdata;
  logic [31:0] w_bank_rdata;
  logic [31:0] w_rd_aligned;

  assign w_off      = req_addr[1:0];
  assign w_word     = req_addr[AW+1:2];
  assign w_n        = size_bytes(req_size[1:0]);
  assign w_mask8    = lane_mask(w_n, w_off);
  assign w_cross    = |w_mask8[7:4];
  assign w_oob      = (req_addr >> (AW + 2)) != '0;
  assign w_accept   = req_valid && r_req_ready && !rst;
  assign w_wdata_lo = req_wdata << {w_off, 3'b000};

`ifdef DMEM_SPLIT_EN
  logic [AW-1:0] r_word;
  logic [31:0]   r_wdata_hi;
  logic [3:0]    r_mask_hi;
  logic [31:0]   r_lo;
  logic          r_cross;
  logic [31:0]   w_wdata_hi;
  logic [31:0]   w_lo;
  logic [31:0]   w_hi;

  assign w_wdata_hi = req_wdata >> (6'd32 - {1'b0, w_off, 3'b000});
`endif

  // All faults are decided at accept, before beat 1 can touch the RAM.
  always_comb begin
    w_err = !size_legal(req_size) || (req_we && req_size[2]) || w_oob;
`ifdef DMEM_SPLIT_EN
    if (w_cross && (&w_word)) w_err = 1'b1;
`else
    if (w_cross) w_err = 1'b1;
`endif
  end

  always_comb begin
    w_bank_en    = 1'b0;
    w_bank_we    = 4'h0;
    w_bank_addr  = w_word;
    w_bank_wdata = w_wdata_lo;
    if (r_state == ST_IDLE) begin
      w_bank_en = w_accept && !w_err;
      if (w_accept && !w_err && req_we) w_bank_we = w_mask8[3:0];
    end
`ifdef DMEM_SPLIT_EN
    else if (r_state == ST_BEAT2) begin
      // A reset landing here cancels beat 2; beat-1 bytes are already committed.
      w_bank_en    = !rst;
      w_bank_addr  = r_word + 1'b1;
      w_bank_wdata = r_wdata_hi;
      if (!rst && r_we) w_bank_we = r_mask_hi;
    end
`endif
  end

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bank (
    .clk    (clk),
    .i_en   (w_bank_en),
    .i_we   (w_bank_we),
    .i_addr (w_bank_addr),
    .i_wdata(w_bank_wdata),
    .o_rdata(w_bank_rdata)
  );

`ifdef DMEM_SPLIT_EN
  assign w_lo         = r_cross ? r_lo : w_bank_rdata;
  assign w_hi         = r_cross ? w_bank_rdata : 32'h0;
  assign w_rd_aligned = (w_lo >> {r_off, 3'b000}) | (w_hi << (6'd32 - {1'b0, r_off, 3'b000}));
`else
  assign w_rd_aligned = w_bank_rdata >> {r_off, 3'b000};
`endif

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_err;
  assign rsp_rdata = (r_rsp_valid && !r_err && !r_we) ? load_extend(r_size, w_rd_aligned) : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_we        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we        <= req_we;
            r_size      <= req_size;
            r_off       <= w_off;
            r_err       <= w_err;
            r_req_ready <= 1'b0;
`ifdef DMEM_SPLIT_EN
            r_word     <= w_word;
            r_wdata_hi <= w_wdata_hi;
            r_mask_hi  <= w_mask8[7:4];
            r_cross    <= w_cross && !w_err;
            if (w_cross && !w_err) begin
              r_state <= ST_BEAT2;
            end else begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
            end
`else
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
`endif
          end
        end
`ifdef DMEM_SPLIT_EN
        ST_BEAT2: begin
          r_lo        <= w_bank_rdata;
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_err       <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed vector bench for data_mem_ctrl; expectations follow DMEM_SPLIT_EN when defined.
module tb_data_mem_ctrl;

  localparam int DW = 256;
`ifdef DMEM_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [2:0]  req_size = 3'b010;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_size (req_size),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
    logic [3:0]  lat;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [2:0] s,
                              input logic [31:0] w, input logic [31:0] d, input logic e,
                              input logic [3:0] l);
    return '{we, a, s, w, d, e, l};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered and left at a falling edge with the controller idle.
  task automatic do_req(input string nm, input logic we, input logic [31:0] addr,
                        input logic [2:0] sz, input logic [31:0] wd, input logic [31:0] exp_d,
                        input logic exp_e, input int exp_lat);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_size  = sz;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid !== 1'b1 && n < 20);
    chk({nm, " latency"}, n, exp_lat);
    chk({nm, " valid/ready"}, {30'b0, rsp_valid, req_ready}, 32'd2);
    chk({nm, " rdata"}, rsp_rdata, exp_d);
    chk({nm, " err"}, {31'b0, rsp_err}, {31'b0, exp_e});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(1, 32'h10,  3'b010, 32'hDEADBEEF, 32'h0, 0, 1);
    vt[1]  = mk(0, 32'h10,  3'b010, 32'h0, 32'hDEADBEEF, 0, 1);
    vt[2]  = mk(1, 32'h21,  3'b000, 32'h80, 32'h0, 0, 1);
    vt[3]  = mk(0, 32'h21,  3'b000, 32'h0, 32'hFFFFFF80, 0, 1);
    vt[4]  = mk(0, 32'h21,  3'b100, 32'h0, 32'h00000080, 0, 1);
    vt[5]  = mk(0, 32'h20,  3'b010, 32'h0, 32'h00008000, 0, 1);
    vt[6]  = mk(1, 32'h0,   3'b010, 32'h11223344, 32'h0, 0, 1);
    vt[7]  = mk(1, 32'h3,   3'b001, 32'h0000AABB, 32'h0, !SPLIT, SPLIT ? 4'd2 : 4'd1);
    vt[8]  = mk(0, 32'h0,   3'b010, 32'h0, SPLIT ? 32'hBB223344 : 32'h11223344, 0, 1);
    vt[9]  = mk(0, 32'h4,   3'b100, 32'h0, SPLIT ? 32'h000000AA : 32'h0, 0, 1);
    vt[10] = mk(0, 32'h3,   3'b001, 32'h0, SPLIT ? 32'hFFFFAABB : 32'h0, !SPLIT, SPLIT ? 4'd2 : 4'd1);
    vt[11] = mk(0, 32'h1,   3'b101, 32'h0, 32'h00002233, 0, 1);
    vt[12] = mk(0, 32'h12,  3'b000, 32'h0, 32'hFFFFFFAD, 0, 1);
    vt[13] = mk(0, 32'h12,  3'b001, 32'h0, 32'hFFFFDEAD, 0, 1);
    vt[14] = mk(0, 32'h10,  3'b101, 32'h0, 32'h0000BEEF, 0, 1);
    vt[15] = mk(0, 32'h11,  3'b010, 32'h0, SPLIT ? 32'h00DEADBE : 32'h0, !SPLIT, SPLIT ? 4'd2 : 4'd1);
    vt[16] = mk(0, 32'h400, 3'b010, 32'h0, 32'h0, 1, 1);
    vt[17] = mk(0, 32'h0,   3'b011, 32'h0, 32'h0, 1, 1);
    vt[18] = mk(1, 32'h0,   3'b100, 32'h55, 32'h0, 1, 1);
    vt[19] = mk(1, 32'h3FE, 3'b010, 32'h55667788, 32'h0, 1, 1);
    vt[20] = mk(0, 32'h3FC, 3'b010, 32'h0, 32'h0, 0, 1);
    vt[21] = mk(0, 32'h0,   3'b100, 32'h0, 32'h00000044, 0, 1);
    vt[22] = mk(1, 32'h3FF, 3'b000, 32'h9A, 32'h0, 0, 1);
    vt[23] = mk(0, 32'h3FC, 3'b010, 32'h0, 32'h9A000000, 0, 1);
    vt[24] = mk(0, 32'h3FF, 3'b000, 32'h0, 32'hFFFFFF9A, 0, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err", {31'b0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Store crossing words 1/2, reset lands while beat 2 (or the error response) is pending.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h7;
    req_size  = 3'b010;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst req_ready", {31'b0, req_ready}, 32'd1);
    do_req("midrst lw4", 1'b0, 32'h4, 3'b010, 32'h0, SPLIT ? 32'h0D000000 : 32'h0, 1'b0, 1);
    do_req("midrst lw8", 1'b0, 32'h8, 3'b010, 32'h0, 32'h0, 1'b0, 1);

    for (int i = 0; i < NV; i++) begin
      do_req($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].sz, vt[i].wd,
             vt[i].exp_d, vt[i].exp_e, int'(vt[i].lat));
    end

    // Hold the response for 5 cycles, then issue a request right after the handshake.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_size  = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d rsp_valid", k), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("hold%0d rsp_rdata", k), rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("hold%0d req_ready", k), {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("b2b req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = 32'h13;
    req_size  = 3'b100;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("b2b rsp_rdata", rsp_rdata, 32'h000000DE);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("b2b idle", {30'b0, rsp_valid, req_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, handshaked data memory for the RISC-V core's load/store path. It replaces the combinational-read, fixed-8 KiB byte array with a synchronous-read memory of configurable depth. It uses valid/ready request and response channels and RV32 load sign/zero extension. Word-crossing accesses are either split into two beats or reported as errors. It sits between the load/store unit and the backing storage.

## Interface
- ADDR_W, 32, byte-address width
- DEPTH_WORDS, 2048, number of 32-bit words (power of two); capacity = 4*DEPTH_WORDS bytes
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  byte address
- req_size  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_wdata  input  32  store data, low bytes used for B/H
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_rdata  output  32  load result, extended; 0 for stores and errors
- rsp_err  output  1  access faulted; no memory state changed

## Operation
- Accept = req_valid && req_ready, sampled at a rising edge. Request fields are captured at accept.
- Byte count n = 1/2/4 from req_size; off = req_addr[1:0]; word = req_addr >> 2.
- Crossing access: off + n > 4.
- Error conditions, checked at accept before any write:
  - req_size in {011, 110, 111}
  - req_we with size 100/101
  - word >= DEPTH_WORDS
  - crossing access with word+1 >= DEPTH_WORDS (no wrap-around)
  - crossing access with DMEM_SPLIT_EN undefined
- On error: straight to RESP with rsp_err=1 and rsp_rdata=0.
- Byte order is little-endian. Stores write only the n addressed byte lanes. Other lanes are preserved.
- Loads: B/H are sign-extended from bit 7/15. BU/HU are zero-extended. W is returned as-is.
- FSM states:
  - IDLE: req_ready=1. On a legal accept, beat 1 (word `word`) runs in the same edge. The FSM then goes to BEAT2 if the access crosses a word, otherwise to RESP. On an error accept it goes to RESP.
  - BEAT2: accesses word+1 for the remaining bytes, then goes to RESP.
  - RESP: rsp_valid=1. Outputs are held stable until rsp_ready, then the FSM returns to IDLE.
- rsp_valid and req_ready are never high together.

## Timing
- Reset values: state IDLE, req_ready=1 from the first cycle after reset, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Memory contents are not reset. They are zero at time 0 in simulation.
- Read data is registered, with 1-cycle memory latency.
- Latency, with accept at edge N:
  - aligned or error: rsp_valid is high after edge N+1
  - split: rsp_valid is high after edge N+2
- Throughput with rsp_ready tied high: one access per 2 cycles (aligned), one per 3 cycles (split).
- Back-to-back: a new request can be accepted on the edge after rsp handshake, when the FSM is back in IDLE.
- A store is visible to a load accepted on any later edge.
- rst asserted mid-operation:
  - the FSM returns to IDLE and any pending response is dropped
  - in BEAT2 of a split store, beat-1 bytes stay written and beat-2 bytes are not written

## Configuration
- DMEM_SPLIT_EN defined: word-crossing accesses run as the two-beat BEAT2 sequence.
- DMEM_SPLIT_EN undefined: the BEAT2 state and its datapath are not compiled. Any crossing access returns rsp_err=1 after 1 cycle with no write. Non-crossing unaligned accesses (e.g. H at off=1) still succeed.

## Structure
- Shared package dmem_pkg holds:
  - funct3 size encodings (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU)
  - FSM state enum
  - byte-count/lane-mask helper functions
- Sub-module dmem_bank: four byte-wide synchronous RAM lanes (DEPTH_WORDS entries each) with per-lane write enable and a registered 32-bit read. The controller does lane rotation, merging and extension.

## Test plan
- Reset then SW 0xDEADBEEF @0x10, LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 1 cycle after accept.
- SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080; LW @0x20 -> 0x00008000.
- SW 0x11223344 @0x0, SH 0xAABB @0x3:
  - with split: LW @0x0 -> 0xBB223344, LBU @0x4 -> 0xAA, response 2 cycles after accept
  - without split: rsp_err=1 and memory unchanged
- LW @ 4*DEPTH_WORDS -> rsp_err=1, rsp_rdata=0. req_size=011 -> rsp_err=1. SW crossing the last word -> rsp_err=1, nothing written.
- Hold rsp_ready=0 for 5 cycles after an LW: rsp_valid and rsp_rdata stay stable and req_ready stays 0. Release rsp_ready and issue a new request 1 cycle later: it is accepted.
- Split SW 0xCAFEF00D @0x7 with rst asserted during BEAT2 -> LW @0x4 = 0x0D000000, LW @0x8 = 0x00000000; rsp_valid=0 after reset.
